return_addr_stack: RTL and testbench
====================================

// Module: return_addr_stack
// PURPOSE
//  Speculative return-address stack (RAS) feeding RETURN/RETURN_ADDR of the branch history table.
//  Fetch-time predicted calls push PC+4; predicted returns pop.
//  A committed copy is updated from EX-resolved calls/returns. FLUSH restores the speculative stack from it exactly.
// PARAMETERS
//  ADDR_WIDTH   32   address width
//  STACK_DEPTH  16   entries (power of 2, >=2)
//  PTR_WIDTH    logb2(STACK_DEPTH)   localparam, stack pointer width
// PORTS
//  CLK               in   1           clock, all state on rising edge
//  RSTN              in   1           reset, synchronous, active-low
//  CACHE_READY       in   1           pipeline advance qualifier
//  CACHE_READY_DATA  in   1           pipeline advance qualifier; EN = CACHE_READY & CACHE_READY_DATA
//  FE_PC             in   ADDR_WIDTH  fetch-stage PC
//  FE_CALL           in   1           fetch instr predicted call (jal/jalr, rd in {x1,x5})
//  FE_RET            in   1           fetch instr predicted return (jalr rs1 in {x1,x5}, rd=x0)
//  EX_PC             in   ADDR_WIDTH  EX-stage PC
//  EX_CALL           in   1           EX-resolved call
//  EX_RET            in   1           EX-resolved return
//  FLUSH             in   1           mispredict/redirect; discard speculative state
//  RETURN_VALID      out  1           speculative stack non-empty
//  RETURN_ADDR       out  ADDR_WIDTH  speculative top of stack, 0 when empty
//  RAS_OVERFLOW      out  1           1-cycle pulse: push evicted oldest speculative entry
//  RAS_UNDERFLOW     out  1           1-cycle pulse: speculative pop on empty stack
// BEHAVIOUR
//  Reset (RSTN=0 at edge): both pointers and counts = 0; RETURN_VALID=0, RETURN_ADDR=0, pulses=0.
//   Entry arrays are not reset. Reset overrides all other inputs, including mid-flush.
//  State per stack: mem[STACK_DEPTH], ptr (next free slot, wraps mod STACK_DEPTH), cnt (0..STACK_DEPTH).
//  Top = mem[ptr-1], modulo arithmetic. RETURN_ADDR = (cnt!=0) ? top : 0.
//   Combinational from registers; a push is visible the cycle after the edge.
//  All updates require EN=1. With EN=0, state holds, pulses=0, and FLUSH/FE_*/EX_* are ignored.
//  Push value = PC + 4, truncated to ADDR_WIDTH; wraps at 2^ADDR_WIDTH.
//  Operation per stack per edge, from (CALL, RET):
//   - (1,0) push: mem[ptr]<=val; ptr++; cnt<=min(cnt+1,DEPTH).
//     When full, the oldest entry is overwritten; speculative stack raises RAS_OVERFLOW.
//   - (0,1) pop: if cnt>0 then ptr--, cnt--. If cnt==0, no change; speculative stack raises RAS_UNDERFLOW.
//   - (1,1) replace: mem[ptr-1]<=val, ptr/cnt unchanged. If cnt==0, acts as push.
//   - (0,0) hold.
//  Committed stack applies (EX_CALL, EX_RET, EX_PC) every EN edge, including FLUSH cycles.
//  Speculative stack, EN=1:
//   - FLUSH=0: applies (FE_CALL, FE_RET, FE_PC).
//   - FLUSH=1: FE_* ignored; spec mem/ptr/cnt <= committed values after this edge's EX update.
//     Same-cycle EX op is included. Pulses = 0.
//  Committed stack never reads speculative state. Overflow/underflow are not reported for it.
// STRUCTURE
//  Shared header pipeline_defs.vh: logb2 function, RISC-V link-register indices (x1, x5).
//  Sub-module ras_stack #(ADDR_WIDTH,STACK_DEPTH), instanced twice (spec, committed):
//   inputs EN, PUSH, POP, PUSH_ADDR, LOAD, LOAD_MEM/LOAD_PTR/LOAD_CNT;
//   outputs TOP, CNT, PTR, MEM (flattened), OVF, UNF.
//   The committed instance ties LOAD=0.
//  Top level: EN gating, PC+4 adders, FLUSH load wiring, output muxing.
// TESTING
//  1 Reset, then 3 FE_CALL at FE_PC=0x100,0x200,0x300 -> RETURN_ADDR 0x104,0x204,0x304 on successive cycles; RETURN_VALID=1.
//  2 From test 1, FE_RET x4 -> RETURN_ADDR 0x204,0x104,0 (VALID=0).
//    4th pop: RAS_UNDERFLOW=1 for one cycle; cnt stays 0.
//  3 DEPTH=16: 17 FE_CALL at PC=0x1000+16*k -> RAS_OVERFLOW on 17th only; top=0x1104.
//    Then 16 pops return 0x1104..0x1014; next pop underflows (0x1004 lost).
//  4 EX_CALL PC=0x40 committed; FE_CALL 0x80,0x90 speculative; FLUSH with EX_CALL PC=0x50 same cycle
//    -> next cycle RETURN_ADDR=0x54, cnt=2, then pop -> 0x44.
//  5 FE_CALL+FE_RET same cycle, PC=0x600, top=0x104 -> top becomes 0x604, cnt unchanged.
//    Same on empty stack -> push, cnt=1.
//  6 EN=0 while FE_CALL/FLUSH asserted -> no change.
//    RSTN=0 during FLUSH with EN=1 -> both stacks empty, outputs 0.

Source files
------------

// File: rtl/return_addr_stack_pkg.sv
// Shared definitions for the return-address stack: pointer sizing, link-register
// indices and the per-edge stack operation encoding.
package return_addr_stack_pkg;

  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  typedef enum logic [1:0] {OP_HOLD, OP_PUSH, OP_POP, OP_REPL} ras_op_e;

  function automatic int logb2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return r;
  endfunction

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/return_addr_stack_ras_stack.sv
// Circular return-address stack. NXT_* expose the state this edge will commit,
// so a sibling stack can be loaded with the result of the same-edge update.
module ras_stack
  import return_addr_stack_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int STACK_DEPTH = 16,
  parameter int PTR_WIDTH   = logb2(STACK_DEPTH)
) (
  input  logic                                    CLK,
  input  logic                                    RSTN,
  input  logic                                    EN,
  input  logic                                    PUSH,
  input  logic                                    POP,
  input  logic [ADDR_WIDTH-1:0]                   PUSH_ADDR,
  input  logic                                    LOAD,
  input  logic [STACK_DEPTH-1:0][ADDR_WIDTH-1:0]  LOAD_MEM,
  input  logic [PTR_WIDTH-1:0]                    LOAD_PTR,
  input  logic [PTR_WIDTH:0]                      LOAD_CNT,
  output logic [ADDR_WIDTH-1:0]                   TOP,
  output logic [PTR_WIDTH:0]                      CNT,
  output logic [STACK_DEPTH-1:0][ADDR_WIDTH-1:0]  NXT_MEM,
  output logic [PTR_WIDTH-1:0]                    NXT_PTR,
  output logic [PTR_WIDTH:0]                      NXT_CNT,
  output logic                                    OVF,
  output logic                                    UNF
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(STACK_DEPTH);

  logic [STACK_DEPTH-1:0][ADDR_WIDTH-1:0] mem;
  logic [PTR_WIDTH-1:0]                   ptr, ptr_m1;
  logic [PTR_WIDTH:0]                     cnt;
  logic                                   ovf_nxt, unf_nxt;
  ras_op_e                                op;

  assign ptr_m1 = ptr - PTR_WIDTH'(1);
  assign TOP    = (cnt != '0) ? mem[ptr_m1] : '0;
  assign CNT    = cnt;

  always_comb begin
    op = OP_HOLD;
    if (PUSH && (!POP || cnt == '0)) op = OP_PUSH;
    else if (PUSH)                   op = OP_REPL;
    else if (POP)                    op = OP_POP;
  end

  always_comb begin
    NXT_MEM = mem;
    NXT_PTR = ptr;
    NXT_CNT = cnt;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (EN) begin
      if (LOAD) begin
        NXT_MEM = LOAD_MEM;
        NXT_PTR = LOAD_PTR;
        NXT_CNT = LOAD_CNT;
      end else begin
        case (op)
          OP_PUSH: begin
            // a full stack wraps onto its oldest slot, which the new entry replaces
            NXT_MEM[ptr] = PUSH_ADDR;
            NXT_PTR      = ptr + PTR_WIDTH'(1);
            if (cnt == FULL_CNT) ovf_nxt = 1'b1;
            else                 NXT_CNT = cnt + (PTR_WIDTH+1)'(1);
          end
          OP_REPL: NXT_MEM[ptr_m1] = PUSH_ADDR;
          OP_POP: begin
            if (cnt != '0) begin
              NXT_PTR = ptr_m1;
              NXT_CNT = cnt - (PTR_WIDTH+1)'(1);
            end else begin
              unf_nxt = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    mem <= NXT_MEM;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      ptr <= '0;
      cnt <= '0;
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else begin
      ptr <= NXT_PTR;
      cnt <= NXT_CNT;
      OVF <= ovf_nxt;
      UNF <= unf_nxt;
    end
  end

endmodule

// File: rtl/return_addr_stack.sv
// Speculative RAS fed at fetch plus a committed RAS fed from EX; FLUSH rebuilds the
// speculative copy from the committed one as updated on the same edge.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int STACK_DEPTH = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic [ADDR_WIDTH-1:0] FE_PC,
  input  logic                  FE_CALL,
  input  logic                  FE_RET,
  input  logic [ADDR_WIDTH-1:0] EX_PC,
  input  logic                  EX_CALL,
  input  logic                  EX_RET,
  input  logic                  FLUSH,
  output logic                  RETURN_VALID,
  output logic [ADDR_WIDTH-1:0] RETURN_ADDR,
  output logic                  RAS_OVERFLOW,
  output logic                  RAS_UNDERFLOW
);

  localparam int PTR_WIDTH = logb2(STACK_DEPTH);

  logic                                   en;
  logic [ADDR_WIDTH-1:0]                  fe_ret_addr, ex_ret_addr;
  logic [STACK_DEPTH-1:0][ADDR_WIDTH-1:0] c_nxt_mem, s_nxt_mem;
  logic [PTR_WIDTH-1:0]                   c_nxt_ptr, s_nxt_ptr;
  logic [PTR_WIDTH:0]                     c_nxt_cnt, s_nxt_cnt, c_cnt, s_cnt;
  logic [ADDR_WIDTH-1:0]                  c_top;
  logic                                   c_ovf, c_unf;
  logic                                   unused_sig;

  assign en          = CACHE_READY & CACHE_READY_DATA;
  assign fe_ret_addr = FE_PC + ADDR_WIDTH'(4);
  assign ex_ret_addr = EX_PC + ADDR_WIDTH'(4);

  ras_stack #(.ADDR_WIDTH(ADDR_WIDTH), .STACK_DEPTH(STACK_DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_cmt (
    .CLK(CLK), .RSTN(RSTN), .EN(en),
    .PUSH(EX_CALL), .POP(EX_RET), .PUSH_ADDR(ex_ret_addr),
    .LOAD(1'b0), .LOAD_MEM('0), .LOAD_PTR('0), .LOAD_CNT('0),
    .TOP(c_top), .CNT(c_cnt),
    .NXT_MEM(c_nxt_mem), .NXT_PTR(c_nxt_ptr), .NXT_CNT(c_nxt_cnt),
    .OVF(c_ovf), .UNF(c_unf)
  );

  ras_stack #(.ADDR_WIDTH(ADDR_WIDTH), .STACK_DEPTH(STACK_DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_spec (
    .CLK(CLK), .RSTN(RSTN), .EN(en),
    .PUSH(FE_CALL), .POP(FE_RET), .PUSH_ADDR(fe_ret_addr),
    .LOAD(FLUSH), .LOAD_MEM(c_nxt_mem), .LOAD_PTR(c_nxt_ptr), .LOAD_CNT(c_nxt_cnt),
    .TOP(RETURN_ADDR), .CNT(s_cnt),
    .NXT_MEM(s_nxt_mem), .NXT_PTR(s_nxt_ptr), .NXT_CNT(s_nxt_cnt),
    .OVF(RAS_OVERFLOW), .UNF(RAS_UNDERFLOW)
  );

  assign RETURN_VALID = (s_cnt != '0);

  // committed top/pulses and speculative look-ahead have no consumer here
  assign unused_sig = ^{c_top, c_cnt, c_ovf, c_unf, s_nxt_mem, s_nxt_ptr, s_nxt_cnt};

endmodule

// File: tb/tb_return_addr_stack.sv
// Random + directed bench for return_addr_stack against a queue-based stack model.
module tb_return_addr_stack;
  localparam int AW = 32;
  localparam int D  = 16;

  logic          CLK = 1'b0;
  logic          RSTN, CACHE_READY, CACHE_READY_DATA;
  logic [AW-1:0] FE_PC, EX_PC, RETURN_ADDR;
  logic          FE_CALL, FE_RET, EX_CALL, EX_RET, FLUSH;
  logic          RETURN_VALID, RAS_OVERFLOW, RAS_UNDERFLOW;

  return_addr_stack #(.ADDR_WIDTH(AW), .STACK_DEPTH(D)) dut (
    .CLK(CLK), .RSTN(RSTN), .CACHE_READY(CACHE_READY), .CACHE_READY_DATA(CACHE_READY_DATA),
    .FE_PC(FE_PC), .FE_CALL(FE_CALL), .FE_RET(FE_RET),
    .EX_PC(EX_PC), .EX_CALL(EX_CALL), .EX_RET(EX_RET), .FLUSH(FLUSH),
    .RETURN_VALID(RETURN_VALID), .RETURN_ADDR(RETURN_ADDR),
    .RAS_OVERFLOW(RAS_OVERFLOW), .RAS_UNDERFLOW(RAS_UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // model: queue bottom at index 0, top at [$]
  logic [AW-1:0] sq[$];
  logic [AW-1:0] cq[$];
  bit            m_ovf, m_unf;

  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_op(input bit spec, input bit call, input bit ret, input logic [AW-1:0] pc);
    logic [AW-1:0] q[$];
    logic [AW-1:0] v;
    v = pc + 32'd4;
    q = spec ? sq : cq;
    if (call && ret && q.size() != 0) begin
      q[q.size()-1] = v;
    end else if (call) begin
      if (q.size() == D) begin
        void'(q.pop_front());
        if (spec) m_ovf = 1'b1;
      end
      q.push_back(v);
    end else if (ret) begin
      if (q.size() != 0) void'(q.pop_back());
      else if (spec) m_unf = 1'b1;
    end
    if (spec) sq = q; else cq = q;
  endfunction

  task automatic model_edge();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (!RSTN) begin
      sq.delete();
      cq.delete();
    end else if (CACHE_READY && CACHE_READY_DATA) begin
      m_op(1'b0, EX_CALL, EX_RET, EX_PC);
      if (FLUSH) sq = cq;
      else       m_op(1'b1, FE_CALL, FE_RET, FE_PC);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    #1;
    chk("valid", {31'd0, RETURN_VALID}, {31'd0, sq.size() != 0});
    chk("addr",  RETURN_ADDR, (sq.size() != 0) ? sq[sq.size()-1] : '0);
    chk("ovf",   {31'd0, RAS_OVERFLOW},  {31'd0, m_ovf});
    chk("unf",   {31'd0, RAS_UNDERFLOW}, {31'd0, m_unf});
  endtask

  task automatic drv(input bit call, input bit ret, input logic [AW-1:0] pc,
                     input bit xcall, input bit xret, input logic [AW-1:0] xpc,
                     input bit flush);
    CACHE_READY = 1'b1; CACHE_READY_DATA = 1'b1;
    FE_CALL = call; FE_RET = ret; FE_PC = pc;
    EX_CALL = xcall; EX_RET = xret; EX_PC = xpc;
    FLUSH = flush;
    cyc();
  endtask

  initial begin
    RSTN = 1'b0;
    CACHE_READY = 1'b0; CACHE_READY_DATA = 1'b0;
    FE_CALL = 0; FE_RET = 0; FE_PC = '0; EX_CALL = 0; EX_RET = 0; EX_PC = '0; FLUSH = 0;
    cyc(); cyc();
    chk("rst_valid", {31'd0, RETURN_VALID}, 32'd0);
    chk("rst_addr",  RETURN_ADDR, 32'd0);
    RSTN = 1'b1;

    // three pushes
    drv(1, 0, 32'h100, 0, 0, 0, 0); chk("t1_a", RETURN_ADDR, 32'h104);
    drv(1, 0, 32'h200, 0, 0, 0, 0); chk("t1_b", RETURN_ADDR, 32'h204);
    drv(1, 0, 32'h300, 0, 0, 0, 0); chk("t1_c", RETURN_ADDR, 32'h304);
    chk("t1_valid", {31'd0, RETURN_VALID}, 32'd1);

    // pop past empty
    drv(0, 1, 0, 0, 0, 0, 0); chk("t2_a", RETURN_ADDR, 32'h204);
    drv(0, 1, 0, 0, 0, 0, 0); chk("t2_b", RETURN_ADDR, 32'h104);
    drv(0, 1, 0, 0, 0, 0, 0); chk("t2_c", RETURN_ADDR, 32'h0);
    chk("t2_valid", {31'd0, RETURN_VALID}, 32'd0);
    drv(0, 1, 0, 0, 0, 0, 0); chk("t2_unf", {31'd0, RAS_UNDERFLOW}, 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0); chk("t2_unf_clr", {31'd0, RAS_UNDERFLOW}, 32'd0);
    chk("t2_empty", {31'd0, RETURN_VALID}, 32'd0);

    // overflow
    for (int k = 0; k < 17; k++) begin
      drv(1, 0, 32'h1000 + 16 * k, 0, 0, 0, 0);
      chk("t3_ovf", {31'd0, RAS_OVERFLOW}, (k == 16) ? 32'd1 : 32'd0);
    end
    chk("t3_top", RETURN_ADDR, 32'h1104);
    for (int j = 0; j < 16; j++) begin
      chk("t3_pop", RETURN_ADDR, 32'h1104 - 16 * j);
      drv(0, 1, 0, 0, 0, 0, 0);
    end
    chk("t3_drained", {31'd0, RETURN_VALID}, 32'd0);
    drv(0, 1, 0, 0, 0, 0, 0); chk("t3_unf", {31'd0, RAS_UNDERFLOW}, 32'd1);

    // flush restores committed, including same-edge EX call
    drv(0, 0, 0, 1, 0, 32'h40, 0);
    drv(1, 0, 32'h80, 0, 0, 0, 0);
    drv(1, 0, 32'h90, 0, 0, 0, 0); chk("t4_spec", RETURN_ADDR, 32'h94);
    drv(1, 0, 32'hF00, 1, 0, 32'h50, 1);
    chk("t4_flush", RETURN_ADDR, 32'h54);
    chk("t4_flush_ovf", {31'd0, RAS_OVERFLOW}, 32'd0);
    drv(0, 1, 0, 0, 0, 0, 0); chk("t4_pop", RETURN_ADDR, 32'h44);
    drv(0, 1, 0, 0, 0, 0, 0); chk("t4_empty", {31'd0, RETURN_VALID}, 32'd0);

    // replace
    drv(1, 0, 32'h100, 0, 0, 0, 0);
    drv(1, 1, 32'h600, 0, 0, 0, 0); chk("t5_repl", RETURN_ADDR, 32'h604);
    drv(0, 1, 0, 0, 0, 0, 0); chk("t5_cnt1", {31'd0, RETURN_VALID}, 32'd0);
    drv(1, 1, 32'h700, 0, 0, 0, 0); chk("t5_empty_push", RETURN_ADDR, 32'h704);
    drv(0, 1, 0, 0, 0, 0, 0); chk("t5_cnt_push", {31'd0, RETURN_VALID}, 32'd0);

    // EN low ignores everything; reset beats flush
    drv(1, 0, 32'h800, 0, 0, 0, 0);
    CACHE_READY_DATA = 1'b0; FE_CALL = 1; FE_PC = 32'hA00; FLUSH = 1; EX_RET = 1;
    cyc(); chk("t6_en0", RETURN_ADDR, 32'h804);
    CACHE_READY = 1'b0; CACHE_READY_DATA = 1'b1;
    cyc(); chk("t6_en0b", RETURN_ADDR, 32'h804);
    RSTN = 1'b0;
    drv(1, 0, 32'hB00, 1, 0, 32'hC00, 1);
    chk("t6_rst_addr", RETURN_ADDR, 32'h0);
    chk("t6_rst_valid", {31'd0, RETURN_VALID}, 32'd0);
    RSTN = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 1); chk("t6_cmt_empty", {31'd0, RETURN_VALID}, 32'd0);

    // random
    for (int i = 0; i < 3000; i++) begin
      CACHE_READY      = ($urandom_range(0, 9) != 0);
      CACHE_READY_DATA = ($urandom_range(0, 9) != 0);
      FE_CALL = $urandom_range(0, 2) == 0;
      FE_RET  = $urandom_range(0, 2) == 0;
      FE_PC   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      EX_CALL = $urandom_range(0, 2) == 0;
      EX_RET  = $urandom_range(0, 2) == 0;
      EX_PC   = $urandom & 32'hFFFF_FFFC;
      FLUSH   = $urandom_range(0, 19) == 0;
      RSTN    = $urandom_range(0, 299) != 0;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
